// File: rtl/reg_dump_reader.sv
// reg_dump_reader: debug readout engine for the register file.
// Walks an inclusive register index range through a dedicated combinational
// read port and streams each captured word over a valid/ready handshake.
// The core is held via cpu_halt for the whole dump.
module reg_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              cpu_halt,
    output logic              done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] READ = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    localparam logic [ADDR_W-1:0] MAX_IDX = ADDR_W'(NUM_REGS - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] end_idx;
    logic              at_end;
    logic              handshake;

    // Range end detection; also stops at the last physical register so the
    // walk can never wrap back to index 0.
    always_comb begin
        at_end    = (idx == end_idx) || (idx == MAX_IDX);
        handshake = out_valid && out_ready;
    end

    // Status and read-port outputs derived from the current state and index.
    always_comb begin
        rd_addr  = idx;
        busy     = (state != IDLE);
        cpu_halt = (state != IDLE);
        done     = (state == FIN);
    end

    // Dump sequencer: latch range, read one word, hold it until accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            end_idx   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx     <= first_addr;
                        end_idx <= last_addr;
                        if (first_addr > last_addr) begin
                            state <= FIN;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    out_data  <= rd_data;
                    out_index <= idx;
                    out_last  <= at_end;
                    out_valid <= 1'b1;
                    state     <= SEND;
                end
                SEND: begin
                    if (handshake) begin
                        out_valid <= 1'b0;
                        if (at_end) begin
                            state <= FIN;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= READ;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: self-checking bench for reg_dump_reader.
// A behavioural model (queue of expected indices plus expected cycle numbers
// for valid/done) is checked against the DUT on every falling clock edge.
module tb_reg_dump_reader;

    localparam int NR = 32;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic [AW-1:0] first_addr = '0;
    logic [AW-1:0] last_addr = '0;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] out_index;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    logic          cpu_halt;
    logic          done;

    logic [DW-1:0] regs [NR];

    reg_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .first_addr(first_addr),
        .last_addr(last_addr),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_index(out_index),
        .out_last(out_last),
        .busy(busy),
        .cpu_halt(cpu_halt),
        .done(done)
    );

    // Register file read port is combinational on the current contents.
    assign rd_data = regs[rd_addr];

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state
    int            q[$];
    int            valid_cyc = 0;
    int            done_cyc = -1;
    int            acc_cyc = 0;
    int            done_seen_cyc = 0;
    int            busy_cycles = 0;
    int            done_count = 0;
    bit            m_busy = 1'b0;
    logic [DW-1:0] exp_data = '0;

    // Words actually handed over, for literal end-of-test checks
    int            hs_idx[$];
    logic [DW-1:0] hs_data[$];
    bit            hs_last[$];

    // Compare process: DUT outputs against the model every cycle
    always @(negedge clk) begin
        bit ev;
        if (reset) begin
            q.delete();
            m_busy   = 1'b0;
            done_cyc = -1;
        end else begin
            ev = (q.size() > 0) && (cyc >= valid_cyc);
            chk("busy", busy, m_busy);
            chk("cpu_halt", cpu_halt, m_busy);
            chk("done", done, cyc == done_cyc);
            chk("out_valid", out_valid, ev);
            if (q.size() > 0 && cyc == valid_cyc - 1) begin
                chk("rd_addr", rd_addr, q[0]);
                exp_data = regs[q[0]];
            end
            if (ev) begin
                chk("out_index", out_index, q[0]);
                chk("out_data", out_data, exp_data);
                chk("out_last", out_last, q.size() == 1);
            end
            if (busy) busy_cycles++;
            if (done) begin
                done_count++;
                done_seen_cyc = cyc;
            end
            if (ev && out_ready) begin
                hs_idx.push_back(int'(out_index));
                hs_data.push_back(out_data);
                hs_last.push_back(out_last);
                void'(q.pop_front());
                if (q.size() == 0) done_cyc = cyc + 1;
                else               valid_cyc = cyc + 2;
            end
            if (m_busy) begin
                if (cyc == done_cyc) m_busy = 1'b0;
            end else if (start) begin
                m_busy  = 1'b1;
                acc_cyc = cyc;
                if (first_addr > last_addr) begin
                    done_cyc = cyc + 1;
                end else begin
                    done_cyc  = -1;
                    valid_cyc = cyc + 2;
                    for (int i = int'(first_addr); i <= int'(last_addr); i++) q.push_back(i);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One dump: hold = cycles ready is forced low after start,
    // rnd_ready = random ready afterwards, pulse = random start during dump,
    // writes = random register writes during dump.
    task automatic run(input int f, input int l, input int hold,
                       input bit rnd_ready, input bit pulse, input bit writes);
        int k;
        bit seen;
        hs_idx.delete();
        hs_data.delete();
        hs_last.delete();
        busy_cycles = 0;
        done_count  = 0;
        first_addr  = AW'(f);
        last_addr   = AW'(l);
        start       = 1'b1;
        out_ready   = (hold > 0) ? 1'b0 : 1'b1;
        tick();
        start = 1'b0;
        k     = 0;
        seen  = 1'b0;
        while (!seen && k < 600) begin
            out_ready = (k < hold) ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
            if (pulse) start = 1'($urandom_range(0, 1));
            if (writes && $urandom_range(0, 3) == 0) regs[$urandom_range(0, NR - 1)] = $urandom;
            tick();
            if (done_count > 0) seen = 1'b1;
            k++;
        end
        start = 1'b0;
        chk("dump_timeout", seen, 1'b1);
    endtask

    int e_idx[3] = '{1, 2, 3};
    logic [DW-1:0] e_dat[3] = '{32'h11111111, 32'h22222222, 32'h33333333};

    initial begin
        int k;
        int f;
        int l;
        for (int i = 0; i < NR; i++) regs[i] = '0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_index", out_index, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        tick();

        // Range 1..3
        regs[1] = 32'h11111111;
        regs[2] = 32'h22222222;
        regs[3] = 32'h33333333;
        run(1, 3, 0, 0, 0, 0);
        chk("t1_count", hs_idx.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_idx", hs_idx[i], e_idx[i]);
            chk("t1_data", hs_data[i], e_dat[i]);
            chk("t1_last", hs_last[i], i == 2);
        end
        chk("t1_latency", done_seen_cyc - acc_cyc, 7);
        chk("t1_busy_cycles", busy_cycles, 7);

        // Full dump 0..31
        for (int i = 0; i < NR; i++) regs[i] = i * 32'h01010101;
        run(0, 31, 0, 0, 0, 0);
        chk("full_count", hs_idx.size(), 32);
        chk("full_latency", done_seen_cyc - acc_cyc, 65);
        chk("full_x0", hs_data[0], 32'h0);
        chk("full_idx31", hs_idx[31], 31);
        chk("full_data31", hs_data[31], 32'h1f1f1f1f);
        chk("full_last31", hs_last[31], 1);

        // Backpressure: 5 cycles of ready low on first word
        run(4, 5, 6, 0, 0, 0);
        chk("bp_count", hs_idx.size(), 2);
        chk("bp_idx0", hs_idx[0], 4);
        chk("bp_data0", hs_data[0], 32'h04040404);
        chk("bp_idx1", hs_idx[1], 5);
        chk("bp_latency", done_seen_cyc - acc_cyc, 10);

        // Single register
        run(7, 7, 0, 0, 0, 0);
        chk("single_count", hs_idx.size(), 1);
        chk("single_last", hs_last[0], 1);
        chk("single_latency", done_seen_cyc - acc_cyc, 3);

        // Empty range
        run(9, 3, 0, 0, 0, 0);
        chk("empty_count", hs_idx.size(), 0);
        chk("empty_latency", done_seen_cyc - acc_cyc, 1);
        chk("empty_busy_cycles", busy_cycles, 1);

        // Start pulsed during a dump
        run(0, 3, 0, 0, 1, 0);
        chk("pulse_count", hs_idx.size(), 4);
        chk("pulse_done_count", done_count, 1);
        repeat (2) tick();

        // Start held high across FIN re-accepts on the first IDLE edge
        done_count  = 0;
        first_addr  = AW'(9);
        last_addr   = AW'(3);
        start       = 1'b1;
        repeat (5) tick();
        start = 1'b0;
        repeat (3) tick();
        chk("held_start_done_count", done_count, 3);

        // Reset while in SEND
        first_addr = AW'(0);
        last_addr  = AW'(10);
        out_ready  = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        while (!out_valid && k < 10) begin
            tick();
            k++;
        end
        chk("rs_reach_send", out_valid, 1);
        repeat (2) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs_rd_addr", rd_addr, 0);
        chk("rs_out_valid", out_valid, 0);
        chk("rs_out_data", out_data, 0);
        chk("rs_out_index", out_index, 0);
        chk("rs_out_last", out_last, 0);
        chk("rs_busy", busy, 0);
        chk("rs_cpu_halt", cpu_halt, 0);
        chk("rs_done", done, 0);
        done_count = 0;
        out_ready  = 1'b1;
        repeat (3) tick();
        chk("rs_no_done", done_count, 0);
        run(2, 2, 0, 0, 0, 0);
        chk("rs_after_count", hs_idx.size(), 1);
        chk("rs_after_idx", hs_idx[0], 2);

        // Randomized dumps
        for (int n = 0; n < 40; n++) begin
            f = $urandom_range(0, NR - 1);
            if ($urandom_range(0, 5) == 0) l = $urandom_range(0, NR - 1);
            else                           l = $urandom_range(f, NR - 1);
            run(f, l, $urandom_range(0, 3), 1, 1'($urandom_range(0, 1)), 1);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
Debug readout engine for the 32x32 register file. On a start request it walks a register address range, drives a register-file read port, and captures each word. It then streams every word out over a valid/ready handshake, with the register index and a last flag. It sits beside the core's register file on a dedicated read port and asserts a halt request so the core freezes while a dump is in progress.

Parameters:
NUM_REGS, 32, number of architectural registers
ADDR_W, 5, register address width (log2 NUM_REGS)
DATA_W, 32, register data width

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  dump request; sampled only in IDLE
first_addr  input  ADDR_W  first register index of range, latched on accepted start
last_addr  input  ADDR_W  last register index of range (inclusive), latched on accepted start
rd_addr  output  ADDR_W  address to register-file read port
rd_data  input  DATA_W  combinational read data returned for rd_addr
out_valid  output  1  out_data/out_index/out_last valid
out_ready  input  1  consumer accepts word when out_valid && out_ready at rising edge
out_data  output  DATA_W  captured register value
out_index  output  ADDR_W  register index of out_data
out_last  output  1  word is final of range
busy  output  1  high in any state other than IDLE
cpu_halt  output  1  halt request to core; equals busy
done  output  1  one-cycle pulse at end of dump

Behaviour:
- Reset (synchronous): state=IDLE. rd_addr=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, cpu_halt=0, done=0. Internal idx and end registers are cleared. Reset mid-dump abandons the dump immediately with no done pulse, and any pending word is dropped.
- States: IDLE, READ, SEND, FIN.
- IDLE: if start=1, latch first_addr into idx and last_addr into end.
  - If first_addr > last_addr: go to FIN and send no words.
  - Otherwise: go to READ.
  - start=0: stay in IDLE.
- READ (one cycle): rd_addr=idx. At the edge, out_data<=rd_data, out_index<=idx, out_last<=(idx==end), out_valid<=1, and the block goes to SEND.
- SEND: out_valid=1, and all out_* fields are held stable until the handshake.
  - Handshake when idx==end: out_valid<=0 and go to FIN.
  - Handshake otherwise: idx<=idx+1, out_valid<=0, go to READ.
  - No handshake: stay in SEND.
- FIN (one cycle): done=1, then IDLE. busy is high through FIN and drops in the IDLE cycle.
- rd_addr holds idx in every state and is only required to be meaningful in READ.
- Latency, start accepted at edge k:
  - READ occupies cycle k+1.
  - out_valid is first high in cycle k+2.
  - With out_ready held at 1, each word takes 2 cycles. N words give done in cycle k+2N+1.
- Start handling: start is ignored while busy. A start held high through FIN is accepted again on the first IDLE edge.
- Wrap: idx never increments past end, so a range ending at NUM_REGS-1 never wraps to 0.
- Single-register range (first==last): exactly one word, with out_last=1.
- Register x0 is read like any other index, and its returned value is passed through unmodified.
- Write/capture ordering: if the register file is written at the same edge that READ captures, the pre-write value is sent, because the read is combinational on the current contents.
- out_ready is ignored when out_valid=0.

Test Plan:
- Reset, preload x1..x3 = 0x11111111, 0x22222222, 0x33333333. Start with first=1, last=3 and out_ready=1 → 3 words, index 1,2,3 with those data; out_last only on index 3; done one cycle after the last handshake; busy/cpu_halt high throughout.
- Full dump 0..31 with each xN=N*0x01010101 and out_ready=1 → 32 words in order, x0 reads 0; done exactly 65 cycles after start is accepted; no wrap past index 31.
- Backpressure: range 4..5, out_ready low for 5 cycles on the first word → out_valid, out_data, and out_index held stable for all 5 cycles; the word is accepted when out_ready rises; the second word follows correctly.
- Boundary ranges: first=7, last=7 → a single word with out_last=1. first=9, last=3 → no out_valid ever; done pulses one cycle after start; busy is high for 1 cycle.
- start pulsed repeatedly during a dump 0..3 → ignored; exactly 4 words and one done pulse.
- Reset asserted while in SEND during range 0..10 → the next cycle shows all outputs at reset values, no done pulse; a new start 2..2 then behaves normally.
